cv32e40s_data_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the single OBI data bus between the LSU (requester 0) and a secondary data master (requester 1). It sits between the requesters' OBI request/response ports and the data bus interface. It grants the bus round-robin, keeps a granted but unaccepted request stable, and records the owner of every outstanding transfer in an in-order FIFO so bus responses return to the correct requester.

---
 rtl/cv32e40s_data_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_cv32e40s_data_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_data_bus_arbiter.sv
// Round-robin arbiter sharing the OBI data bus between the LSU and a second master.
// Optional CV32E40S_DBA_DRAIN_ON_SWITCH_EN: owner changes only when nothing is in flight.
package cv32e40s_dba_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_data_resp_t;
endpackage

module cv32e40s_data_bus_arbiter
  import cv32e40s_dba_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid_i,
  input  obi_data_req_t [1:0] req_trans_i,
  output logic [1:0]          req_ready_o,
  output logic [1:0]          resp_valid_o,
  output obi_data_resp_t      resp_o,
  output logic                valid_o,
  output obi_data_req_t       trans_o,
  input  logic                ready_i,
  input  logic                resp_valid_i,
  input  obi_data_resp_t      resp_i,
  output logic                busy_o,
  output logic                protocol_err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH-1);

  logic                 last_q;
  logic                 lock_q;
  logic                 lock_sel_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [DEPTH-1:0]     fifo_q;

  logic sel;
  logic full;
  logic accept;
  logic stall;
  logic resp_ok;
  logic head;

  // A stalled request keeps the bus; ties and idle favour the other side.
  always_comb begin
    sel = !last_q;
    if (lock_q) begin
      sel = lock_sel_q;
    end
`ifdef CV32E40S_DBA_DRAIN_ON_SWITCH_EN
    else if (cnt_q != '0) begin
      sel = last_q;
    end
`endif
    else if (req_valid_i == 2'b01) begin
      sel = 1'b0;
    end else if (req_valid_i == 2'b10) begin
      sel = 1'b1;
    end
  end

  assign full    = (cnt_q == CNT_MAX);
  assign valid_o = req_valid_i[sel] && !full;
  assign trans_o = req_trans_i[sel];
  assign accept  = valid_o && ready_i;
  assign stall   = valid_o && !ready_i;

  assign req_ready_o[0] = ready_i && !full && !sel;
  assign req_ready_o[1] = ready_i && !full && sel;

  assign resp_ok        = resp_valid_i && (cnt_q != '0);
  assign head           = fifo_q[rd_ptr_q];
  assign resp_valid_o   = {resp_ok && head, resp_ok && !head};
  assign resp_o         = resp_i;
  assign protocol_err_o = resp_valid_i && (cnt_q == '0);
  assign busy_o         = (cnt_q != '0) || (|req_valid_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else begin
      lock_q <= stall;
      if (stall) begin
        lock_sel_q <= sel;
      end
      if (accept) begin
        last_q <= sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fifo_q   <= '0;
    end else begin
      if (accept) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (resp_ok) begin
        rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
      end
      if (accept && !resp_ok) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!accept && resp_ok) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40s_data_bus_arbiter.sv
// Randomised scoreboard bench for cv32e40s_data_bus_arbiter.
// Owners of outstanding transfers are tracked in a plain queue.
module tb_cv32e40s_data_bus_arbiter;
  import cv32e40s_dba_pkg::*;

  localparam int DEPTH = 2;
`ifdef CV32E40S_DBA_DRAIN_ON_SWITCH_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req_valid_i = '0;
  obi_data_req_t [1:0] req_trans_i = '0;
  logic [1:0]          req_ready_o;
  logic [1:0]          resp_valid_o;
  obi_data_resp_t      resp_o;
  logic                valid_o;
  obi_data_req_t       trans_o;
  logic                ready_i = 1'b0;
  logic                resp_valid_i = 1'b0;
  obi_data_resp_t      resp_i = '0;
  logic                busy_o;
  logic                protocol_err_o;

  cv32e40s_data_bus_arbiter #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_trans_i    (req_trans_i),
    .req_ready_o    (req_ready_o),
    .resp_valid_o   (resp_valid_o),
    .resp_o         (resp_o),
    .valid_o        (valid_o),
    .trans_o        (trans_o),
    .ready_i        (ready_i),
    .resp_valid_i   (resp_valid_i),
    .resp_i         (resp_i),
    .busy_o         (busy_o),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             orphan;
    bit             owner;
    obi_data_resp_t resp;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t          exp_q[$];
  bit            outst_q[$];
  logic [1:0]    pend = '0;
  obi_data_req_t ptrans[2];
  bit            m_last = 1'b1;
  bit            m_lock = 1'b0;
  bit            m_lock_sel = 1'b0;
  bit            allow_orphan = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic obi_data_req_t rand_req();
    obi_data_req_t r;
    r.addr  = $urandom;
    r.we    = 1'($urandom);
    r.be    = 4'($urandom);
    r.wdata = $urandom;
    return r;
  endfunction

  function automatic void model_reset();
    outst_q.delete();
    pend       = '0;
    m_last     = 1'b1;
    m_lock     = 1'b0;
    m_lock_sel = 1'b0;
  endfunction

  // One bus cycle: drive, check the request path, then advance the model.
  task automatic step(input logic [1:0] nv, input logic rdy,
                      input logic rvi);
    logic [1:0] v;
    logic [1:0] erdy;
    bit         s;
    bit         full;
    bit         ev;
    bit         rv;
    exp_t       e;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      if (!pend[n] && nv[n]) begin
        pend[n]   = 1'b1;
        ptrans[n] = rand_req();
      end
    end
    v  = pend;
    rv = rvi && (outst_q.size() != 0 || allow_orphan);
    req_valid_i    = v;
    req_trans_i[0] = ptrans[0];
    req_trans_i[1] = ptrans[1];
    ready_i        = rdy;
    resp_valid_i   = rv;
    resp_i.rdata   = $urandom;
    resp_i.err     = 1'($urandom);
    #1;
    full = (outst_q.size() == DEPTH);
    if (m_lock) s = m_lock_sel;
    else if (DRAIN && outst_q.size() != 0) s = m_last;
    else if (v == 2'b01) s = 1'b0;
    else if (v == 2'b10) s = 1'b1;
    else s = !m_last;
    ev   = v[s] && !full;
    erdy = (rdy && !full) ? (s ? 2'b10 : 2'b01) : 2'b00;
    chk("valid_o", 128'(valid_o), 128'(ev));
    chk("req_ready_o", 128'(req_ready_o), 128'(erdy));
    chk("busy_o", 128'(busy_o),
        128'(outst_q.size() != 0 || v != 2'b00));
    if (ev) chk("trans_o", 128'(trans_o), 128'(ptrans[s]));
    if (rv) begin
      e.orphan = (outst_q.size() == 0);
      e.owner  = e.orphan ? 1'b0 : outst_q.pop_front();
      e.resp   = resp_i;
      exp_q.push_back(e);
    end
    if (ev && rdy) begin
      outst_q.push_back(s);
      m_last  = s;
      pend[s] = 1'b0;
    end
    m_lock = ev && !rdy;
    if (m_lock) m_lock_sel = s;
  endtask

  task automatic drain_all();
    repeat (6) step(2'b00, 1'b1, 1'b1);
  endtask

  // Response monitor: pops the expected routing whenever the bus answers.
  always @(negedge clk) begin
    exp_t   e;
    logic [1:0] erv;
    #2;
    if (rst_n && (resp_valid_i || resp_valid_o != 2'b00 || protocol_err_o)) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 128'(resp_valid_o), 128'(2'b00));
      end else begin
        e   = exp_q.pop_front();
        erv = e.orphan ? 2'b00 : (e.owner ? 2'b10 : 2'b01);
        chk("resp_valid_o", 128'(resp_valid_o), 128'(erv));
        chk("protocol_err_o", 128'(protocol_err_o), 128'(e.orphan));
        chk("resp_o", 128'(resp_o), 128'(e.resp));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ptrans[0] = '0;
    ptrans[1] = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid_o", 128'(valid_o), 128'(0));
    chk("rst_req_ready", 128'(req_ready_o), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_perr", 128'(protocol_err_o), 128'(0));
    rst_n = 1'b1;

    step(2'b11, 1'b1, 1'b0);
    chk("tie_first", 128'(req_ready_o), 128'(2'b01));
    step(2'b11, 1'b1, 1'b0);
    chk("tie_second", 128'(req_ready_o),
        128'(DRAIN ? 2'b01 : 2'b10));
    step(2'b11, 1'b1, 1'b1);
    chk("full_block", 128'(valid_o), 128'(0));
    step(2'b11, 1'b1, 1'b1);
    chk("full_reopen", 128'(req_ready_o), 128'(2'b01));
    drain_all();

    repeat (3) begin
      step(2'b10, 1'b0, 1'b0);
      chk("stall_ready", 128'(req_ready_o), 128'(0));
    end
    step(2'b11, 1'b0, 1'b0);
    chk("lock_trans", 128'(trans_o), 128'(ptrans[1]));
    step(2'b11, 1'b1, 1'b0);
    chk("lock_grant", 128'(req_ready_o), 128'(2'b10));
    drain_all();

`ifdef CV32E40S_DBA_DRAIN_ON_SWITCH_EN
    step(2'b01, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    chk("drain_same", 128'(req_ready_o), 128'(2'b01));
    step(2'b00, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b1);
    step(2'b00, 1'b1, 1'b0);
    chk("drain_switch", 128'(req_ready_o), 128'(2'b10));
    drain_all();
`endif

    allow_orphan = 1'b1;
    step(2'b00, 1'b0, 1'b1);
    chk("orphan_err", 128'(protocol_err_o), 128'(1));
    chk("orphan_rv", 128'(resp_valid_o), 128'(0));
    step(2'b00, 1'b0, 1'b0);
    chk("orphan_cnt", 128'(busy_o), 128'(0));
    allow_orphan = 1'b0;

    repeat (2000) begin
      step({1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0)},
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    while (outst_q.size() == 0) step(2'b11, 1'b1, 1'b0);
    @(negedge clk);
    req_valid_i  = '0;
    ready_i      = 1'b0;
    resp_valid_i = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy_o), 128'(0));
    chk("mid_rst_rv", 128'(resp_valid_o), 128'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    allow_orphan = 1'b1;
    step(2'b00, 1'b0, 1'b1);
    chk("mid_rst_orphan", 128'(protocol_err_o), 128'(1));
    allow_orphan = 1'b0;

    drain_all();
    step(2'b00, 1'b0, 1'b0);
    chk("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
